rv32_decode_unit: RTL and testbench

- Combinational RV32I instruction decoder for the front end of the out-of-order core, between fetch and rename/dispatch.
- Extracts register specifiers and a sign-extended immediate, and generates ALU, branch and memory control signals plus a functional-unit type.
- Passes PC and the valid/ready handshake through unchanged.
- A small clocked block keeps a sticky illegal-opcode flag and a decoded-instruction counter for debug.

---
 rtl/rv32_decode_unit.sv | 155 +++++++++++++++
 tb/tb_rv32_decode_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rv32_decode_unit.sv
// rtl/rv32_decode_unit.sv - RV32I combinational decoder with valid/ready passthrough and debug counters
module rv32_decode_unit #(
  parameter int PC_WIDTH  = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic                 i_valid,
  input  logic                 i_ready,
  output logic                 o_ready,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic                 o_valid,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 ALUsrc,
  output logic                 Branch,
  output logic [31:0]          immediate,
  output logic [1:0]           ALUOp,
  output logic [1:0]           FUtype,
  output logic                 Memread,
  output logic                 Memwrite,
  output logic                 Regwrite,
  output logic                 illegal,
  output logic                 illegal_sticky,
  output logic [CNT_WIDTH-1:0] decode_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BRU = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;
  logic        accept;

  logic                 illegal_sticky_q, illegal_sticky_d;
  logic [CNT_WIDTH-1:0] decode_count_q, decode_count_d;

  assign o_valid = i_valid;
  assign o_ready = i_ready;
  assign o_pc    = i_pc;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  always_comb begin
    rs1       = 5'd0;
    rs2       = 5'd0;
    immediate = 32'd0;
    ALUsrc    = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    FUtype    = FU_ALU;
    Memread   = 1'b0;
    Memwrite  = 1'b0;
    Regwrite  = 1'b0;
    illegal   = 1'b0;
    unique case (opcode)
      OP_R: begin
        rs1      = instruction[19:15];
        rs2      = instruction[24:20];
        ALUOp    = 2'b10;
        Regwrite = 1'b1;
      end
      OP_IMM: begin
        rs1       = instruction[19:15];
        immediate = imm_i;
        ALUsrc    = 1'b1;
        ALUOp     = 2'b11;
        Regwrite  = 1'b1;
      end
      OP_LOAD: begin
        rs1       = instruction[19:15];
        immediate = imm_i;
        ALUsrc    = 1'b1;
        FUtype    = FU_LSU;
        Memread   = 1'b1;
        Regwrite  = 1'b1;
      end
      OP_STORE: begin
        rs1       = instruction[19:15];
        rs2       = instruction[24:20];
        immediate = imm_s;
        ALUsrc    = 1'b1;
        FUtype    = FU_LSU;
        Memwrite  = 1'b1;
      end
      OP_BRANCH: begin
        rs1       = instruction[19:15];
        rs2       = instruction[24:20];
        immediate = imm_b;
        Branch    = 1'b1;
        ALUOp     = 2'b01;
        FUtype    = FU_BRU;
      end
      OP_JALR: begin
        rs1       = instruction[19:15];
        immediate = imm_i;
        ALUsrc    = 1'b1;
        Branch    = 1'b1;
        FUtype    = FU_BRU;
        Regwrite  = 1'b1;
      end
      // LUI leaves Regwrite low on purpose; rename handles it elsewhere
      OP_LUI: begin
        immediate = imm_u;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign accept = i_valid && i_ready;

  always_comb begin
    illegal_sticky_d = illegal_sticky_q;
    decode_count_d   = decode_count_q;
    if (accept) begin
      decode_count_d = decode_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (illegal) illegal_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_sticky_q <= 1'b0;
      decode_count_q   <= '0;
    end else begin
      illegal_sticky_q <= illegal_sticky_d;
      decode_count_q   <= decode_count_d;
    end
  end

  assign illegal_sticky = illegal_sticky_q;
  assign decode_count   = decode_count_q;

endmodule

// File: tb/tb_rv32_decode_unit.sv
// tb/tb_rv32_decode_unit.sv - directed self-checking bench for rv32_decode_unit
module tb_rv32_decode_unit;

  localparam int PC_WIDTH  = 9;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0]          instruction;
  logic [PC_WIDTH-1:0]  i_pc;
  logic                 i_valid, i_ready;
  logic                 o_ready, o_valid;
  logic [PC_WIDTH-1:0]  o_pc;
  logic [4:0]           rs1, rs2, rd;
  logic                 ALUsrc, Branch, Memread, Memwrite, Regwrite;
  logic [31:0]          immediate;
  logic [1:0]           ALUOp, FUtype;
  logic                 illegal, illegal_sticky;
  logic [CNT_WIDTH-1:0] decode_count;

  int vectors = 0;
  int miscompares = 0;

  rv32_decode_unit #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .i_pc(i_pc),
    .i_valid(i_valid), .i_ready(i_ready), .o_ready(o_ready), .o_pc(o_pc),
    .o_valid(o_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .ALUsrc(ALUsrc),
    .Branch(Branch), .immediate(immediate), .ALUOp(ALUOp), .FUtype(FUtype),
    .Memread(Memread), .Memwrite(Memwrite), .Regwrite(Regwrite),
    .illegal(illegal), .illegal_sticky(illegal_sticky), .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ctrl packing: {ALUsrc, Branch, ALUOp, FUtype, Memread, Memwrite, Regwrite, illegal}
  task automatic decode(input string tag, input logic [31:0] instr,
                        input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                        input logic [31:0] e_imm, input logic [9:0] e_ctrl);
    instruction = instr;
    #1;
    check({tag, ".rs1"}, {27'd0, rs1}, {27'd0, e_rs1});
    check({tag, ".rs2"}, {27'd0, rs2}, {27'd0, e_rs2});
    check({tag, ".rd"},  {27'd0, rd},  {27'd0, e_rd});
    check({tag, ".imm"}, immediate, e_imm);
    check({tag, ".ctrl"},
          {22'd0, ALUsrc, Branch, ALUOp, FUtype, Memread, Memwrite, Regwrite, illegal},
          {22'd0, e_ctrl});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instruction = 32'd0; i_pc = '0; i_valid = 1'b0; i_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset.count",  {16'd0, decode_count}, 32'd0);
    check("reset.sticky", {31'd0, illegal_sticky}, 32'd0);

    decode("add",   32'h003100B3, 5'd2,  5'd3,  5'd1,  32'd0,          10'b0_0_10_00_0_0_1_0);
    decode("addi+", 32'h02A30293, 5'd6,  5'd0,  5'd5,  32'd42,         10'b1_0_11_00_0_0_1_0);
    decode("addi-", 32'hFFF40393, 5'd8,  5'd0,  5'd7,  32'hFFFFFFFF,   10'b1_0_11_00_0_0_1_0);
    decode("lw",    32'h0085A503, 5'd11, 5'd0,  5'd10, 32'd8,          10'b1_0_00_10_1_0_1_0);
    decode("sw",    32'h00C6A823, 5'd13, 5'd12, 5'd16, 32'd16,         10'b1_0_00_10_0_1_0_0);
    decode("sw-1",  32'hFE000FA3, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF,   10'b1_0_00_10_0_1_0_0);
    decode("beq",   32'h00F70463, 5'd14, 5'd15, 5'd8,  32'd8,          10'b0_1_01_01_0_0_0_0);
    decode("beq-2", 32'hFE000FE3, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFE,   10'b0_1_01_01_0_0_0_0);
    decode("lui",   32'h12345837, 5'd0,  5'd0,  5'd16, 32'h12345000,   10'b0_0_00_00_0_0_0_0);
    decode("jalr",  32'h004100E7, 5'd2,  5'd0,  5'd1,  32'd4,          10'b1_1_00_01_0_0_1_0);
    decode("ill7f", 32'hFFFFFFFF, 5'd0,  5'd0,  5'd31, 32'd0,          10'b0_0_00_00_0_0_0_1);
    check("noacc.count", {16'd0, decode_count}, 32'd0);

    @(negedge clk);
    i_valid = 1'b1; i_ready = 1'b1; i_pc = 9'h100; instruction = 32'h003100B3;
    #1;
    check("pass.valid", {31'd0, o_valid}, 32'd1);
    check("pass.ready", {31'd0, o_ready}, 32'd1);
    check("pass.pc",    {23'd0, o_pc},    32'h100);
    i_valid = 1'b0; i_ready = 1'b0;
    #1;
    check("pass0.valid", {31'd0, o_valid}, 32'd0);
    check("pass0.ready", {31'd0, o_ready}, 32'd0);

    // reset has priority over a simultaneous accept
    @(negedge clk);
    reset = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    check("rstprio.count", {16'd0, decode_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick(); tick();
    check("acc3.count",  {16'd0, decode_count}, 32'd3);
    check("acc3.sticky", {31'd0, illegal_sticky}, 32'd0);

    @(negedge clk);
    i_ready = 1'b0;
    tick();
    check("stall.count", {16'd0, decode_count}, 32'd3);

    @(negedge clk);
    instruction = 32'h0000007F; i_valid = 1'b0;
    #1;
    check("ill.comb", {31'd0, illegal}, 32'd1);
    tick();
    check("ill.noacc.sticky", {31'd0, illegal_sticky}, 32'd0);
    @(negedge clk);
    i_valid = 1'b1; i_ready = 1'b1;
    tick();
    check("ill.sticky", {31'd0, illegal_sticky}, 32'd1);
    check("ill.count",  {16'd0, decode_count}, 32'd4);
    @(negedge clk);
    instruction = 32'h003100B3;
    tick();
    check("hold.sticky", {31'd0, illegal_sticky}, 32'd1);
    check("hold.count",  {16'd0, decode_count}, 32'd5);
    @(negedge clk);
    i_valid = 1'b0; reset = 1'b1;
    tick();
    check("clr.sticky", {31'd0, illegal_sticky}, 32'd0);
    check("clr.count",  {16'd0, decode_count}, 32'd0);

    @(negedge clk);
    reset = 1'b0; i_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap.max", {16'd0, decode_count}, 32'hFFFF);
    tick();
    check("wrap.zero", {16'd0, decode_count}, 32'd0);
    @(negedge clk);
    i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
